// File: rtl/mbus_decoder_ws.sv
// Memory-bus decoder for up to 16 slaves in the low 64K, one 4K page per slave.
// Each slave gets its own wait-state count; unmapped accesses raise m_err and are logged.
module mbus_decoder_ws #(
  parameter int                WIDTH    = 32,
  parameter int                NSLV     = 4,
  parameter logic [NSLV*4-1:0] PAGE_MAP = {4'hF, 4'hE, 4'hC, 4'h0},
  parameter logic [NSLV*4-1:0] WS_MAP   = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  m_req,
  input  logic                  m_wen,
  input  logic [WIDTH-1:0]      m_addr,
  input  logic [WIDTH-1:0]      m_wdata,
  output logic [WIDTH-1:0]      m_rdata,
  output logic                  m_ack,
  output logic                  m_err,
  output logic                  m_busy,
  output logic [NSLV-1:0]       s_cs,
  output logic                  s_wen,
  output logic [WIDTH-1:0]      s_addr,
  output logic [WIDTH-1:0]      s_wdata,
  input  logic [NSLV*WIDTH-1:0] s_rdata,
  output logic [WIDTH-1:0]      err_addr,
  output logic [7:0]            err_cnt
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [IW-1:0] sel;
  logic [3:0]    cnt;
  logic          wen_q;
  logic          hit;
  logic [IW-1:0] hit_idx;

  // Scan high-to-low so the lowest matching index overrides the others.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (m_addr[15:12] == PAGE_MAP[i*4 +: 4]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    if (m_addr[WIDTH-1:16] != '0) hit = 1'b0;
  end

  assign m_busy = (state == ACCESS);
  // The strobe lives in the final ACCESS cycle only, so one write per access.
  assign s_wen  = (state == ACCESS) && (cnt == 4'd0) && wen_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      sel      <= '0;
      cnt      <= '0;
      wen_q    <= 1'b0;
      s_cs     <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      m_rdata  <= '0;
      m_ack    <= 1'b0;
      m_err    <= 1'b0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m_req) begin
            if (hit) begin
              sel     <= hit_idx;
              s_addr  <= m_addr;
              s_wdata <= m_wdata;
              wen_q   <= m_wen;
              cnt     <= WS_MAP[hit_idx*4 +: 4];
              s_cs    <= NSLV'(1) << hit_idx;
              state   <= ACCESS;
            end else begin
              m_err    <= 1'b1;
              err_addr <= m_addr;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            m_rdata <= wen_q ? '0 : s_rdata[sel*WIDTH +: WIDTH];
            m_ack   <= 1'b1;
            s_cs    <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_decoder_ws.sv
// Directed bench for mbus_decoder_ws: read/write latency, misses, back-to-back, overlap, reset.
module tb_mbus_decoder_ws;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        m_req = 1'b0, m_wen = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [127:0] s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0BAD_F00D};

  logic [31:0] m_rdata, s_addr, s_wdata, err_addr;
  logic        m_ack, m_err, m_busy, s_wen;
  logic [3:0]  s_cs;
  logic [7:0]  err_cnt;

  logic [31:0] d2_rdata, d2_saddr, d2_swdata, d2_eaddr;
  logic        d2_ack, d2_err, d2_busy, d2_swen;
  logic [3:0]  d2_cs;
  logic [7:0]  d2_ecnt;

  int errors = 0;
  int checks = 0;
  logic wen_seen = 1'b0;

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (s_wen) wen_seen = 1'b1;

  // slave3 WS=1, slave2 WS=5, slave1 WS=3, slave0 WS=0
  mbus_decoder_ws #(.WIDTH(32), .NSLV(4), .PAGE_MAP({4'hF, 4'hE, 4'hC, 4'h0}),
                    .WS_MAP({4'd1, 4'd5, 4'd3, 4'd0})) dut (
    .CLK(CLK), .RESET(RESET), .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .m_busy(m_busy), .s_cs(s_cs), .s_wen(s_wen), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .err_addr(err_addr), .err_cnt(err_cnt));

  // Overlapping map: slaves 1 and 2 both on page E
  mbus_decoder_ws #(.WIDTH(32), .NSLV(4), .PAGE_MAP({4'hF, 4'hE, 4'hE, 4'h0}),
                    .WS_MAP(16'h0000)) dut2 (
    .CLK(CLK), .RESET(RESET), .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(d2_rdata), .m_ack(d2_ack), .m_err(d2_err),
    .m_busy(d2_busy), .s_cs(d2_cs), .s_wen(d2_swen), .s_addr(d2_saddr),
    .s_wdata(d2_swdata), .s_rdata(s_rdata), .err_addr(d2_eaddr), .err_cnt(d2_ecnt));

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (m_rdata !== 32'h0 || err_addr !== 32'h0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: rdata=%h eaddr=%h saddr=%h swdata=%h exp all 0", m_rdata, err_addr, s_addr, s_wdata); end
    checks++; if ({m_ack, m_err, m_busy, s_wen, s_cs, err_cnt} !== 16'h0) begin
      errors++; $display("FAIL reset_ctrl: ack=%b err=%b busy=%b wen=%b cs=%b cnt=%0d exp 0", m_ack, m_err, m_busy, s_wen, s_cs, err_cnt); end
    step(2);
    RESET = 1'b0;
    step(1);
  endtask

  task automatic test_read_ws0;
    m_addr = 32'h0000_0010; m_wen = 1'b0; m_req = 1'b1;
    step();
    m_req = 1'b0;
    checks++; if (s_cs !== 4'b0001 || m_busy !== 1'b1 || m_ack !== 1'b0) begin
      errors++; $display("FAIL rd0_access: cs=%b busy=%b ack=%b exp 0001 1 0", s_cs, m_busy, m_ack); end
    checks++; if (s_addr !== 32'h10) begin errors++; $display("FAIL rd0_saddr: got %h exp 00000010", s_addr); end
    step();
    checks++; if (m_ack !== 1'b1 || s_cs !== 4'b0000 || m_busy !== 1'b0) begin
      errors++; $display("FAIL rd0_ack: ack=%b cs=%b busy=%b exp 1 0000 0", m_ack, s_cs, m_busy); end
    checks++; if (m_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL rd0_data: got %h exp 0badf00d", m_rdata); end
    step();
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL rd0_ack_pulse: got %b exp 0", m_ack); end
  endtask

  task automatic test_write_ws3;
    m_addr = 32'h0000_C004; m_wdata = 32'hDEAD_BEEF; m_wen = 1'b1; m_req = 1'b1;
    step();
    m_req = 1'b0; m_wen = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (s_cs !== 4'b0010 || s_wen !== (i == 3) || s_wdata !== 32'hDEAD_BEEF || m_ack !== 1'b0) begin
        errors++; $display("FAIL wr3_cyc%0d: cs=%b wen=%b wdata=%h ack=%b exp 0010 %0d deadbeef 0", i, s_cs, s_wen, s_wdata, m_ack, (i == 3)); end
      step();
    end
    checks++; if (m_ack !== 1'b1 || m_rdata !== 32'h0 || s_cs !== 4'b0000 || s_wen !== 1'b0) begin
      errors++; $display("FAIL wr3_ack: ack=%b rdata=%h cs=%b wen=%b exp 1 0 0000 0", m_ack, m_rdata, s_cs, s_wen); end
    step();
  endtask

  task automatic test_miss;
    logic cs_seen;
    m_addr = 32'h0001_0000; m_req = 1'b1;
    step();
    m_req = 1'b0;
    checks++; if (m_err !== 1'b1 || m_ack !== 1'b0 || s_cs !== 4'b0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL miss1: err=%b ack=%b cs=%b busy=%b exp 1 0 0000 0", m_err, m_ack, s_cs, m_busy); end
    checks++; if (err_addr !== 32'h0001_0000 || err_cnt !== 8'd1) begin
      errors++; $display("FAIL miss1_log: eaddr=%h cnt=%0d exp 00010000 1", err_addr, err_cnt); end
    step();
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL miss1_pulse: got %b exp 0", m_err); end
    m_addr = 32'h0000_5000; m_req = 1'b1;
    step();
    m_req = 1'b0;
    checks++; if (m_err !== 1'b1 || err_addr !== 32'h0000_5000 || err_cnt !== 8'd2) begin
      errors++; $display("FAIL miss2: err=%b eaddr=%h cnt=%0d exp 1 00005000 2", m_err, err_addr, err_cnt); end
    step();
    cs_seen = 1'b0;
    m_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (s_cs !== 4'b0) cs_seen = 1'b1;
    end
    m_req = 1'b0;
    checks++; if (cs_seen !== 1'b0) begin errors++; $display("FAIL miss_no_cs: cs seen=%b exp 0", cs_seen); end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL miss_sat: got %0d exp 255", err_cnt); end
    step(2);
  endtask

  task automatic test_back_to_back;
    m_addr = 32'h0000_F008; m_wen = 1'b0; m_req = 1'b1;
    step();
    m_addr = 32'h0000_F00C;
    checks++; if (s_cs !== 4'b1000 || s_addr !== 32'h0000_F008) begin
      errors++; $display("FAIL b2b_a0: cs=%b saddr=%h exp 1000 0000f008", s_cs, s_addr); end
    step();
    checks++; if (s_cs !== 4'b1000 || s_addr !== 32'h0000_F008 || m_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_a1: cs=%b saddr=%h ack=%b exp 1000 0000f008 0", s_cs, s_addr, m_ack); end
    step();
    checks++; if (m_ack !== 1'b1 || m_rdata !== 32'h3333_3333 || m_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_ack1: ack=%b rdata=%h busy=%b exp 1 33333333 0", m_ack, m_rdata, m_busy); end
    step();
    m_req = 1'b0;
    checks++; if (m_busy !== 1'b1 || s_addr !== 32'h0000_F00C || m_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_b0: busy=%b saddr=%h ack=%b exp 1 0000f00c 0", m_busy, s_addr, m_ack); end
    step();
    checks++; if (m_ack !== 1'b0 || s_cs !== 4'b1000) begin
      errors++; $display("FAIL b2b_b1: ack=%b cs=%b exp 0 1000", m_ack, s_cs); end
    step();
    checks++; if (m_ack !== 1'b1 || m_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_ack2: ack=%b busy=%b exp 1 0", m_ack, m_busy); end
    step(3);
  endtask

  task automatic test_overlap;
    m_addr = 32'h0000_E000; m_wen = 1'b0; m_req = 1'b1;
    step();
    m_req = 1'b0;
    checks++; if (d2_cs !== 4'b0010) begin errors++; $display("FAIL ovl_cs: got %b exp 0010", d2_cs); end
    checks++; if (s_cs !== 4'b0100) begin errors++; $display("FAIL ovl_ref_cs: got %b exp 0100", s_cs); end
    step();
    checks++; if (d2_ack !== 1'b1 || d2_rdata !== 32'h1111_1111) begin
      errors++; $display("FAIL ovl_data: ack=%b rdata=%h exp 1 11111111", d2_ack, d2_rdata); end
    step(8);
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL ovl_drain: busy=%b exp 0", m_busy); end
  endtask

  task automatic test_reset_mid;
    wen_seen = 1'b0;
    m_addr = 32'h0000_E000; m_wdata = 32'h1234_5678; m_wen = 1'b1; m_req = 1'b1;
    step();
    m_req = 1'b0; m_wen = 1'b0;
    step();
    checks++; if (s_cs !== 4'b0100 || m_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre: cs=%b busy=%b exp 0100 1", s_cs, m_busy); end
    RESET = 1'b1;
    #1;
    checks++; if (s_cs !== 4'b0 || s_wen !== 1'b0 || m_busy !== 1'b0 || m_ack !== 1'b0) begin
      errors++; $display("FAIL rst_async: cs=%b wen=%b busy=%b ack=%b exp 0", s_cs, s_wen, m_busy, m_ack); end
    step(2);
    checks++; if (m_ack !== 1'b0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_hold: ack=%b cnt=%0d exp 0 0", m_ack, err_cnt); end
    RESET = 1'b0;
    step(8);
    checks++; if (wen_seen !== 1'b0 || m_ack !== 1'b0) begin
      errors++; $display("FAIL rst_nowrite: wen_seen=%b ack=%b exp 0 0", wen_seen, m_ack); end
    m_addr = 32'h0000_0020; m_req = 1'b1;
    step();
    m_req = 1'b0;
    checks++; if (s_cs !== 4'b0001 || s_addr !== 32'h20) begin
      errors++; $display("FAIL rst_after_cs: cs=%b saddr=%h exp 0001 00000020", s_cs, s_addr); end
    step();
    checks++; if (m_ack !== 1'b1 || m_rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL rst_after_ack: ack=%b rdata=%h exp 1 0badf00d", m_ack, m_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_read_ws0();
    test_write_ws3();
    test_miss();
    test_back_to_back();
    test_overlap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(posedge CLK) begin
    #2;
    if (m_ack && m_err) begin
      errors++;
      $display("FAIL ack_err_exclusive: ack=%b err=%b exp not both", m_ack, m_err);
    end
  end
endmodule
